// File: rtl/cfg_chain_loader_if.sv
// Host word stream (START/IN_*) and chain-side serial outputs of the
// configuration chain loader, bundled for connection to cfg_chain_loader.
interface cfg_chain_loader_if #(
  parameter int IO_WIDTH = 16
);
  logic                START;
  logic                IN_VALID;
  logic [IO_WIDTH-1:0] IN_DATA;
  logic                IN_READY;
  logic                CFG_WE;
  logic                CFG_D;
  logic                BUSY;
  logic                DONE;

  modport master (
    output START, IN_VALID, IN_DATA,
    input  IN_READY, CFG_WE, CFG_D, BUSY, DONE
  );

  modport slave (
    input  START, IN_VALID, IN_DATA,
    output IN_READY, CFG_WE, CFG_D, BUSY, DONE
  );
endinterface

// File: rtl/cfg_chain_loader.sv
// Configuration chain sequencer: buffers host words in a one-word hold stage and
// shifts every record into the serial CFG chain LSB first, one bit per cycle.
module cfg_chain_loader #(
  parameter int N_LAYER  = 5,
  parameter int IO_WIDTH = 16
) (
  input logic               CLK,
  input logic               RSTB,
  cfg_chain_loader_if.slave bus
);

  localparam int REC_BITS = 128;
  localparam int WPR      = REC_BITS / IO_WIDTH;
  localparam int BIT_W    = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
  localparam int WORD_W   = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int REC_W    = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam int ACC_W    = $clog2(WPR * N_LAYER + 1);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(IO_WIDTH - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WPR - 1);
  localparam logic [REC_W-1:0]  LAST_REC  = REC_W'(N_LAYER - 1);
  localparam logic [ACC_W-1:0]  TOTAL_ACC = ACC_W'(WPR * N_LAYER);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1'b1);
  localparam logic [WORD_W-1:0] WORD_ONE  = WORD_W'(1'b1);
  localparam logic [REC_W-1:0]  REC_ONE   = REC_W'(1'b1);
  localparam logic [ACC_W-1:0]  ACC_ONE   = ACC_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [IO_WIDTH-1:0] hold_r, hold_s;
  logic                hold_full_r, hold_full_s;
  logic [IO_WIDTH-1:0] sreg_r, sreg_s;
  logic                sreg_valid_r, sreg_valid_s;
  logic [BIT_W-1:0]    bit_cnt_r, bit_cnt_s;
  logic [WORD_W-1:0]   word_cnt_r, word_cnt_s;
  logic [REC_W-1:0]    rec_cnt_r, rec_cnt_s;
  logic [ACC_W-1:0]    acc_cnt_r, acc_cnt_s;
  logic                in_ready_r, in_ready_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                accept_s, last_bit_s, xfer_s;

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_s      = state_r;
    hold_s       = hold_r;
    hold_full_s  = hold_full_r;
    sreg_s       = sreg_r;
    sreg_valid_s = sreg_valid_r;
    bit_cnt_s    = bit_cnt_r;
    word_cnt_s   = word_cnt_r;
    rec_cnt_s    = rec_cnt_r;
    acc_cnt_s    = acc_cnt_r;
    accept_s     = bus.IN_VALID && in_ready_r;
    last_bit_s   = sreg_valid_r && (bit_cnt_r == LAST_BIT);
    xfer_s       = hold_full_r && (!sreg_valid_r || last_bit_s);
    case (state_r)
      ST_IDLE: begin
        if (bus.START) begin
          state_s      = ST_LOAD;
          hold_full_s  = 1'b0;
          sreg_s       = '0;
          sreg_valid_s = 1'b0;
          bit_cnt_s    = '0;
          word_cnt_s   = '0;
          rec_cnt_s    = '0;
          acc_cnt_s    = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Zero-fill keeps CFG_D low once the last bit of a word has left.
        if (sreg_valid_r) begin
          sreg_s    = {1'b0, sreg_r[IO_WIDTH-1:1]};
          bit_cnt_s = bit_cnt_r + BIT_ONE;
        end else begin
          sreg_s    = sreg_r;
          bit_cnt_s = bit_cnt_r;
        end
        if (last_bit_s) begin
          sreg_valid_s = 1'b0;
          bit_cnt_s    = '0;
          if (word_cnt_r == LAST_WORD) begin
            word_cnt_s = '0;
            rec_cnt_s  = rec_cnt_r + REC_ONE;
          end else begin
            word_cnt_s = word_cnt_r + WORD_ONE;
            rec_cnt_s  = rec_cnt_r;
          end
          if ((word_cnt_r == LAST_WORD) && (rec_cnt_r == LAST_REC)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          sreg_valid_s = sreg_valid_r;
        end
        if (xfer_s) begin
          sreg_s       = hold_r;
          sreg_valid_s = 1'b1;
          bit_cnt_s    = '0;
          hold_full_s  = 1'b0;
        end else begin
          hold_full_s  = hold_full_r;
        end
        if (accept_s) begin
          hold_s      = bus.IN_DATA;
          hold_full_s = 1'b1;
          acc_cnt_s   = acc_cnt_r + ACC_ONE;
        end else begin
          hold_s      = hold_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    in_ready_s = (state_s == ST_LOAD) && !hold_full_s && (acc_cnt_s < TOTAL_ACC);
    busy_s     = (state_s != ST_IDLE);
    done_s     = (state_s == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      hold_r       <= '0;
      hold_full_r  <= 1'b0;
      sreg_r       <= '0;
      sreg_valid_r <= 1'b0;
      bit_cnt_r    <= '0;
      word_cnt_r   <= '0;
      rec_cnt_r    <= '0;
      acc_cnt_r    <= '0;
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      hold_r       <= hold_s;
      hold_full_r  <= hold_full_s;
      sreg_r       <= sreg_s;
      sreg_valid_r <= sreg_valid_s;
      bit_cnt_r    <= bit_cnt_s;
      word_cnt_r   <= word_cnt_s;
      rec_cnt_r    <= rec_cnt_s;
      acc_cnt_r    <= acc_cnt_s;
      in_ready_r   <= in_ready_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign bus.IN_READY = in_ready_r;
  assign bus.CFG_WE   = sreg_valid_r;
  assign bus.CFG_D    = sreg_r[0];
  assign bus.BUSY     = busy_r;
  assign bus.DONE     = done_r;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: full sessions with streaming, a stall,
// START while busy, backpressure and a mid-session reset.
module tb_cfg_chain_loader;

  localparam int N_WORDS = 40;
  localparam int N_BITS  = 640;

  logic CLK = 1'b0;
  logic RSTB;
  always #5 CLK = ~CLK;

  cfg_chain_loader_if #(.IO_WIDTH(16)) bus ();

  cfg_chain_loader #(.N_LAYER(5), .IO_WIDTH(16)) dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] recs    [5];
  logic [127:0] cap_rec [5];
  logic         cap     [N_BITS];
  int we_cnt, we_rises, first_we, last_we, done_cnt, done_cyc;
  int extra_acc, bp_cycles, d_idle_viol, acc_words, ready_hi;
  logic busy_after_done;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input int k);
    return recs[k/8][16*(k%8) +: 16];
  endfunction

  // One session from START; stall_d withholds word 11 for that many ready cycles,
  // start_cyc re-pulses START, abort_cyc drops RSTB mid-session.
  task automatic run_session(input int stall_d, input int start_cyc, input int abort_cyc);
    int   ptr        = 0;
    int   stall_left = stall_d;
    int   cyc        = 0;
    int   stop_cyc   = 3000;
    logic prev_we    = 1'b0;
    we_cnt = 0; we_rises = 0; first_we = -1; last_we = -1; done_cnt = 0;
    done_cyc = -10; extra_acc = 0; bp_cycles = 0; d_idle_viol = 0; acc_words = 0;
    busy_after_done = 1'b1;
    for (int i = 0; i < N_BITS; i++) cap[i] = 1'b0;
    @(negedge CLK); bus.START = 1'b1;
    @(negedge CLK); bus.START = 1'b0;
    chk("start_busy_ready", {bus.BUSY, bus.IN_READY}, 2'b11);
    while (cyc < stop_cyc) begin
      if (cyc == abort_cyc) begin
        chk("we_before_reset", bus.CFG_WE, 1'b1);
        #2 RSTB = 1'b0;
        #1 chk("outs_in_reset", {bus.IN_READY, bus.CFG_WE, bus.CFG_D, bus.BUSY, bus.DONE}, 5'b0);
        bus.IN_VALID = 1'b0;
        return;
      end
      if (bus.CFG_WE) begin
        if (we_cnt < N_BITS) cap[we_cnt] = bus.CFG_D;
        if (!prev_we) we_rises++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
        we_cnt++;
      end else if (bus.CFG_D) begin
        d_idle_viol++;
      end
      prev_we = bus.CFG_WE;
      if (bus.DONE) begin
        done_cnt++;
        done_cyc = cyc;
        stop_cyc = cyc + 4;
      end
      if (cyc == done_cyc + 1) busy_after_done = bus.BUSY;
      bus.START = (cyc == start_cyc);
      if (ptr == 11 && stall_left > 0) begin
        bus.IN_VALID = 1'b0;
        if (bus.IN_READY) stall_left--;
      end else begin
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = (ptr < N_WORDS) ? word_of(ptr) : 16'hFFFF;
        if (bus.IN_READY && ptr < N_WORDS) begin
          ptr++;
          acc_words++;
        end else if (bus.IN_READY) begin
          extra_acc++;
        end else if (ptr < N_WORDS && bus.BUSY) begin
          bp_cycles++;
        end
      end
      @(negedge CLK);
      cyc++;
    end
    bus.IN_VALID = 1'b0;
    bus.START    = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < 128; b++) cap_rec[r][b] = cap[128*r + b];
  endtask

  task automatic check_session(input string tag, input int exp_last, input int exp_rises);
    chk({tag, "_we_cnt"},    we_cnt,          N_BITS);
    chk({tag, "_first_we"},  first_we,        2);
    chk({tag, "_last_we"},   last_we,         exp_last);
    chk({tag, "_we_rises"},  we_rises,        exp_rises);
    chk({tag, "_done_cnt"},  done_cnt,        1);
    chk({tag, "_done_cyc"},  done_cyc,        exp_last + 1);
    chk({tag, "_busy_off"},  busy_after_done, 1'b0);
    chk({tag, "_acc_words"}, acc_words,       N_WORDS);
    chk({tag, "_extra_acc"}, extra_acc,       0);
    chk({tag, "_d_idle"},    d_idle_viol,     0);
    for (int r = 0; r < 5; r++) chk($sformatf("%s_rec%0d", tag, r), cap_rec[r], recs[r]);
  endtask

  // Idle cycles with IN_VALID high must never show IN_READY.
  task automatic idle_ready_probe(input string tag);
    ready_hi = 0;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus.IN_READY) ready_hi++;
    end
    bus.IN_VALID = 1'b0;
    chk(tag, ready_hi, 0);
  endtask

  initial begin
    recs[0] = {1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 96'hA5A5_5A5A_0123_4567_89AB_CDEF,
               9'd7, 5'd7, 5'd7, 5'd3};
    recs[1] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    recs[2] = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    recs[3] = 128'h8000_0000_0000_0001_FFFF_0000_AAAA_5555;
    recs[4] = 128'h7E81_3C5A_0F0F_F0F0_9669_C33C_1248_8421;

    RSTB = 1'b0;
    bus.START = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA = 16'h0000;
    repeat (3) @(negedge CLK);
    chk("reset_outs", {bus.IN_READY, bus.CFG_WE, bus.CFG_D, bus.BUSY, bus.DONE}, 5'b0);
    RSTB = 1'b1;
    idle_ready_probe("idle_ready_after_reset");

    // Session A: IN_VALID always high.
    run_session(0, -1, -1);
    check_session("A", 641, 1);
    chk("A_backpressure_seen", (bp_cycles > 0), 1'b1);
    chk("A_rec0_hw",    cap_rec[0][4:0],     5'd3);
    chk("A_rec0_t",     cap_rec[0][9:5],     5'd7);
    chk("A_rec0_d1",    cap_rec[0][14:10],   5'd7);
    chk("A_rec0_d2",    cap_rec[0][23:15],   9'd7);
    chk("A_rec0_tpd",   cap_rec[0][123:120], 4'd10);
    chk("A_rec0_flags", cap_rec[0][127:124], 4'b0011);
    chk("A_rec0_word0", cap_rec[0][15:0],    16'h9CE3);
    chk("A_rec0_word7", cap_rec[0][127:112], 16'h3AA5);

    // Session B: word 10 drains in 16 cycles, so a 34-cycle hold-off of word 11
    // leaves a 20-cycle hole in CFG_WE; START is re-pulsed while busy.
    run_session(34, 200, -1);
    check_session("B", 661, 2);

    // Session C: reset dropped while shifting.
    run_session(0, -1, 30);
    repeat (2) @(negedge CLK);
    RSTB = 1'b1;
    chk("busy_after_abort", bus.BUSY, 1'b0);
    idle_ready_probe("idle_ready_after_abort");

    // Session D: full reload after the aborted session.
    run_session(0, -1, -1);
    check_session("D", 641, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
